mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS single-cycle processor, adding MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO support. It sits beside the ALU, directly downstream of the register file: it takes rs/rt read data as operands and holds results in architectural HI/LO registers, which feed the register-file write-data mux. Operations take multiple cycles. The processor control stalls the PC while `busy` is high.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  32  operand rs (multiplicand / dividend)
- b  input  32  operand rt (multiplier / divisor)
- hi_we  input  1  MTHI: write `wdata` into HI
- lo_we  input  1  MTLO: write `wdata` into LO
- wdata  input  32  data for MTHI/MTLO
- busy  output  1  operation in progress; processor must stall
- done  output  1  one-cycle pulse; HI/LO hold the new result
- hi  output  32  HI register (MFHI source)
- lo  output  32  LO register (MFLO source)

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **IDLE**
  - On start=1, latch op. Latch |a| and |b| for signed ops, or raw a and b for unsigned ops.
  - Record the result sign and the dividend sign. Clear the iteration counter (6 bits).
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- **MUL:** radix-2 shift-add over a 64-bit product register. Each cycle:
  - If product[0]=1, add the multiplicand to the upper half with a 33-bit carry.
  - Shift the 64-bit register right by one.
  - After 32 iterations, go to FIX.
- **DIV:** restoring division over a 64-bit remainder/quotient register. Each cycle:
  - Shift left by one.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the result is non-negative, keep it and set quotient bit 1. Otherwise restore.
  - After 32 iterations, go to FIX.
- **FIX:** apply signs and commit.
  - MULT: negate the 64-bit product if the result sign is negative. HI = upper 32 bits, LO = lower 32 bits.
  - DIV: quotient is negated if operand signs differ (truncation toward zero). Remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - Unsigned ops: no negation.
  - Then go to IDLE and pulse done.
- **Divide by zero** (b=0, signed or unsigned): no exception. Result is fixed as LO=32'hFFFFFFFF, HI=a (original, unmodified). The same 32 cycles are used; no early exit.
- **Signed overflow:** DIV 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0. The 33-bit absolute-value datapath must produce this naturally.
- **|a| of 32'h80000000:** handled as an unsigned 32-bit value of 2^31. No truncation.
- **MTHI/MTLO:**
  - Honoured only in IDLE with start=0.
  - Ignored while busy.
  - If start and hi_we/lo_we are asserted together in IDLE, start wins and the write is dropped.
- **start outside IDLE:** ignored; it does not queue.

## Timing
- **Reset:** on any edge with reset=1, the following hold on the next cycle: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. This applies mid-operation too; partial results are discarded.
- **busy:** combinational from state; high in MUL, DIV and FIX, low in IDLE. busy rises in the cycle after the edge that samples start.
- **Latency for start sampled at edge E0:**
  - Iterations occur at edges E1..E32.
  - FIX commits HI/LO at E33.
  - Registered done=1 and busy=0 during the cycle after E33. New hi/lo are visible in that same cycle.
  - Total: 34 cycles from start-visible to done-visible.
- **done:** exactly one cycle high. A new start may be asserted in the done cycle and is accepted, since the FSM is in IDLE.
- **hi/lo:** registered. They hold their previous values throughout the operation and change only at the FIX edge, on reset, or on MTHI/MTLO.
- **MTHI/MTLO:** write at the sampling edge and are visible the next cycle.

## Test plan
- **Reset / MTHI-MTLO:**
  - Assert reset → hi=0, lo=0, busy=0, done=0.
  - hi_we with wdata=32'h1234_5678 → hi=32'h12345678 next cycle; lo unchanged.
- **MULTU:** a=32'hFFFFFFFF, b=32'hFFFFFFFF → after 34 cycles done=1, hi=32'hFFFFFFFE, lo=32'h00000001. busy high for exactly 33 cycles.
- **MULT:** a=-7 (32'hFFFFFFF9), b=6 → hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42).
- **DIV signed:** a=-7, b=2 → lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- **DIVU:** a=100, b=7 → lo=14, hi=2.
- **DIV 32'h80000000 / -1:** lo=32'h80000000, hi=0.
- **Divide by zero:** DIVU a=5, b=0 → lo=32'hFFFFFFFF, hi=5.
- **Mid-operation hazards:**
  - Assert start and lo_we at cycle 10 of a MULT → ignored; the result matches the undisturbed run.
  - Assert reset at cycle 20 → hi=lo=0, busy=0 next cycle, and no done pulse.

Source files
------------

// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - operand/result bundle between the core and the mult/div unit
interface mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mult_div_unit (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [1:0]  op_r;
    logic [31:0] mcand;
    logic [63:0] acc;
    logic [5:0]  cnt;
    logic        res_neg;
    logic        dvd_neg;
    logic        div_zero;
    logic [31:0] a_orig;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [64:0] div_sh;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitudes are treated as unsigned, so |0x80000000| stays 2^31.
    always_comb begin
        abs_a    = (bus.op[0] && bus.a[31]) ? -bus.a : bus.a;
        abs_b    = (bus.op[0] && bus.b[31]) ? -bus.b : bus.b;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
        div_sh   = {acc, 1'b0};
        div_ok   = div_sh[64:32] >= {1'b0, mcand};
        div_diff = div_sh[64:32] - {1'b0, mcand};
        prod_fix = res_neg ? -acc : acc;
        quot_fix = res_neg ? -acc[31:0] : acc[31:0];
        rem_fix  = dvd_neg ? -acc[63:32] : acc[63:32];
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= 2'b00;
            mcand    <= 32'd0;
            acc      <= 64'd0;
            cnt      <= 6'd0;
            res_neg  <= 1'b0;
            dvd_neg  <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= 32'd0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 6'd0;
                    if (bus.start) begin
                        op_r     <= bus.op;
                        res_neg  <= bus.op[0] & (bus.a[31] ^ bus.b[31]);
                        dvd_neg  <= bus.op[0] & bus.a[31];
                        div_zero <= (bus.b == 32'd0);
                        a_orig   <= bus.a;
                        if (bus.op[1]) begin
                            mcand <= abs_b;
                            acc   <= {32'd0, abs_a};
                            state <= DIV;
                        end else begin
                            mcand <= abs_a;
                            acc   <= {32'd0, abs_b};
                            state <= MUL;
                        end
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[31:1]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                DIV: begin
                    if (div_ok) acc <= {div_diff[31:0], div_sh[31:1], 1'b1};
                    else        acc <= div_sh[63:0];
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (!op_r[1]) begin
                        hi_r <= prod_fix[63:32];
                        lo_r <= prod_fix[31:0];
                    end else if (div_zero) begin
                        // Divide by zero returns a fixed pattern, not the datapath result.
                        hi_r <= a_orig;
                        lo_r <= 32'hFFFF_FFFF;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quot_fix;
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;
    int   nbusy;
    int   ndone;

    mult_div_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inj 0: none, 1: start+lo_we with other operands at cycle 10
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int inj);
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        @(negedge clk);
        hold_hi   = bus.hi;
        hold_lo   = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
        n     = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) nbusy++;
            if (n == 5) begin
                check({tag, "_hold_hi"}, {32'd0, bus.hi}, {32'd0, hold_hi});
                check({tag, "_hold_lo"}, {32'd0, bus.lo}, {32'd0, hold_lo});
            end
            if (inj == 1 && n == 10) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.lo_we = 1'b1;
                bus.wdata = 32'h5555_AAAA;
            end
            @(negedge clk);
            bus.start = 1'b0;
            bus.lo_we = 1'b0;
            n++;
        end
        check({tag, "_done"},    {63'd0, bus.done}, 64'd1);
        check({tag, "_latency"}, n, 33);
        check({tag, "_busycyc"}, nbusy, 33);
        check({tag, "_busy0"},   {63'd0, bus.busy}, 64'd0);
        check({tag, "_hilo"},    {bus.hi, bus.lo}, {exp_hi, exp_lo});
        @(negedge clk);
        check({tag, "_pulse"},   {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);

        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'h1234_5678, 32'h0});

        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFE_0001;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, {32'h1234_5678, 32'hCAFE_0001});

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg",  2'b01, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
        run_op("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu",      2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        0);
        run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
        run_op("divu_zero", 2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0);
        run_op("div_zero",  2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        run_op("mult_inj",  2'b01, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1);

        // start together with a write in IDLE: operation runs, write is dropped
        bus.hi_we = 1'b1;
        bus.wdata = 32'h7777_7777;
        run_op("start_wins", 2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 0);
        bus.hi_we = 1'b0;

        // reset partway through a multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) ndone++;
            @(negedge clk);
        end
        check("midrst_nodone", ndone, 0);
        check("midrst_after", {bus.hi, bus.lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
